dmem_stage: RTL and testbench

- MEM-stage data-memory unit between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Performs word loads and stores against an internal multi-cycle data memory.
- Raises a stall so that upstream pipeline registers hold while an access is in flight.
- Presents load data for MEM/WB to capture on the cycle the stall drops.

---
 rtl/dmem_stage.sv | 115 +++++++++++
 tb/tb_dmem_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dmem_stage.sv
// dmem_stage: MEM-stage multi-cycle word data memory that stalls the pipeline.
// Defining DMEM_MISALIGN_CHECK_EN rejects requests with Addr_i[1:0] != 0.
module dmem_stage #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        misalign_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          st_q, st_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem [DEPTH];

  logic req;
  logic mis;
  logic start;
  logic commit;

  logic unused_addr;
  assign unused_addr = ^{Addr_i[31:AW+2], Addr_i[1:0]};

  always_comb begin
    req = MemRead_i | MemWrite_i;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = req & (Addr_i[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    start   = ~rst_i & (state_q == IDLE) & req & ~mis;
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = MemWrite_i;
          idx_d   = Addr_i[AW+1:2];
          wdata_d = WriteData_i;
          if (LATENCY == 1) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // *_d already hold the access being committed, including LATENCY==1
    rdata_d = rdata_q;
    if (commit && !st_d) rdata_d = mem[idx_d];
    if (rst_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      rdata_d = '0;
      commit  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    st_q    <= st_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  always_ff @(posedge clk_i) begin
    if (commit && st_d) mem[idx_d] <= wdata_d;
  end

  assign ReadData_o = rdata_q;
  assign stall_o    = ~rst_i & ((state_q == BUSY) | start);
`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_o = ~rst_i & (state_q == IDLE) & mis;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_stage.sv
// tb_dmem_stage: scoreboard bench for dmem_stage; expected load data and
// stall length are queued at issue and checked when the stall drops.
module tb_dmem_stage;

  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mis;

  int errors = 0;
  int checks = 0;
  int run_len = 0;
  logic [31:0] exp_q[$];

  dmem_stage #(.DEPTH(32), .LATENCY(LAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .MemRead_i  (rd),
    .MemWrite_i (wr),
    .Addr_i     (addr),
    .WriteData_i(wdata),
    .ReadData_o (rdata),
    .stall_o    (stall),
    .misalign_o (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a stall run ending outside reset marks the DONE cycle
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else if (stall) begin
      run_len++;
    end else if (run_len != 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got access expected none");
      end else begin
        check("stall_len", 32'(run_len), 32'(LAT));
        check("rdata", rdata, exp_q.pop_front());
      end
      run_len = 0;
    end
  end

  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp);
    bit seen = 0;
    bit done = 0;
    @(posedge clk); #1;
    rd = r; wr = w; addr = a; wdata = d;
    exp_q.push_back(exp);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall) seen = 1;
      else if (seen) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done expected done addr %h", a);
    end
    @(posedge clk); #1;
    rd = 0; wr = 0; addr = '0; wdata = '0;
  endtask

  initial begin
    rst = 1; rd = 0; wr = 0; addr = '0; wdata = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_rdata", rdata, 32'h0);
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_mis", 32'(mis), 32'h0);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'h0);

    access(0, 1, 32'h10, 32'hDEADBEEF, 32'h0);
    access(1, 0, 32'h10, 32'h0, 32'hDEADBEEF);
    repeat (2) begin
      @(negedge clk);
      check("hold_rdata", rdata, 32'hDEADBEEF);
      check("idle_stall", 32'(stall), 32'h0);
    end

    access(0, 1, 32'h80, 32'h12345678, 32'hDEADBEEF);
    access(1, 0, 32'h00, 32'h0, 32'h12345678);

    access(1, 1, 32'h4, 32'hA5A5A5A5, 32'h12345678);
    access(1, 0, 32'h4, 32'h0, 32'hA5A5A5A5);

    access(0, 1, 32'h8, 32'h22222222, 32'hA5A5A5A5);
    @(posedge clk); #1;
    wr = 1; addr = 32'h8; wdata = 32'h11111111;
    @(posedge clk); #1;
    rst = 1; wr = 0; addr = '0; wdata = '0;
    @(negedge clk);
    check("abort_stall_rst", 32'(stall), 32'h0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("abort_stall", 32'(stall), 32'h0);
    check("abort_rdata", rdata, 32'h0);
    access(1, 0, 32'h8, 32'h0, 32'h22222222);

`ifdef DMEM_MISALIGN_CHECK_EN
    @(posedge clk); #1;
    rd = 1; addr = 32'h6;
    @(negedge clk);
    check("mis_flag", 32'(mis), 32'h1);
    check("mis_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    rd = 0; addr = '0;
    @(negedge clk);
    check("mis_clear", 32'(mis), 32'h0);
    check("mis_rdata", rdata, 32'h22222222);
`else
    access(1, 0, 32'h6, 32'h0, 32'hA5A5A5A5);
    check("mis_tied", 32'(mis), 32'h0);
`endif

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending: got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
